// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix keypad front end: FSM encoding, key codes
// and the (row, column) to key-code map.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_EMIT     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  localparam logic [3:0] COL_IDLE_INIT = 4'b1110;

  // Digits decode to their BCD value; non-digit keys use codes above 9.
  function automatic logic [3:0] key_decode(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'd0;
      4'b11_10: code = KEY_HASH;
      4'b11_11: code = KEY_D;
      default:  code = KEY_HASH;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row inputs; resets to
// the released (all-high) level.
module keypad_row_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n_i,
  output logic [3:0] row_s_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
    end else begin
      meta_q <= row_n_i;
      sync_q <= meta_q;
    end
  end

  assign row_s_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column rotation, press/release debounce and
// one-cycle digit/equals and clear strobes toward the code checker.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] digit,
  output logic       equals,
  output logic       clear,
  output logic       busy
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE);

  logic [3:0]    row_s;
  state_t        state_q;
  logic [SW-1:0] slot_q;
  logic [DW-1:0] deb_q;
  logic [3:0]    col_n_q;
  logic [1:0]    cand_row_q;
  logic [1:0]    cand_col_q;
  logic [3:0]    digit_q;
  logic          equals_q;
  logic          clear_q;
  logic          busy_q;

  logic          sample_s;
  logic          row_one_s;
  logic [1:0]    row_idx_s;
  logic [1:0]    col_idx_s;
  logic          row_match_s;
  logic          emit_now_s;
  logic [3:0]    emit_key_s;

  keypad_row_sync u_row_sync (
    .clk     (clk),
    .reset   (reset),
    .row_n_i (row_n),
    .row_s_o (row_s)
  );

  always_comb begin
    sample_s  = (slot_q == SLOT_LAST);
    row_one_s = 1'b1;
    row_idx_s = 2'd0;
    case (row_s)
      4'b1110: row_idx_s = 2'd0;
      4'b1101: row_idx_s = 2'd1;
      4'b1011: row_idx_s = 2'd2;
      4'b0111: row_idx_s = 2'd3;
      default: row_one_s = 1'b0;
    endcase
    case (col_n_q)
      4'b1110: col_idx_s = 2'd0;
      4'b1101: col_idx_s = 2'd1;
      4'b1011: col_idx_s = 2'd2;
      4'b0111: col_idx_s = 2'd3;
      default: col_idx_s = 2'd0;
    endcase
    row_match_s = (row_s == ~(4'b0001 << cand_row_q));
    // With DEBOUNCE==1 the first sample in SCAN already completes the press.
    emit_now_s = sample_s &&
                 (((state_q == ST_SCAN) && row_one_s && (DEB_MAX == DW'(1))) ||
                  ((state_q == ST_DEBOUNCE) && row_match_s && ((deb_q + DW'(1)) == DEB_MAX)));
    emit_key_s = (state_q == ST_SCAN) ? key_decode(row_idx_s, col_idx_s)
                                      : key_decode(cand_row_q, cand_col_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_SCAN;
      slot_q     <= '0;
      deb_q      <= '0;
      col_n_q    <= COL_IDLE_INIT;
      cand_row_q <= 2'd0;
      cand_col_q <= 2'd0;
      digit_q    <= 4'd0;
      equals_q   <= 1'b0;
      clear_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      slot_q   <= sample_s ? '0 : slot_q + SW'(1);
      equals_q <= 1'b0;
      clear_q  <= 1'b0;

      if (emit_now_s) begin
        if (emit_key_s <= 4'd9) begin
          digit_q  <= emit_key_s;
          equals_q <= 1'b1;
        end else if (emit_key_s == KEY_STAR) begin
          clear_q <= 1'b1;
        end
      end

      case (state_q)
        ST_SCAN: begin
          if (sample_s) begin
            if (row_one_s) begin
              cand_row_q <= row_idx_s;
              cand_col_q <= col_idx_s;
              deb_q      <= DW'(1);
              busy_q     <= 1'b1;
              state_q    <= emit_now_s ? ST_EMIT : ST_DEBOUNCE;
            end else begin
              col_n_q <= {col_n_q[2:0], col_n_q[3]};
            end
          end
        end
        ST_DEBOUNCE: begin
          if (sample_s) begin
            if (row_match_s) begin
              deb_q <= deb_q + DW'(1);
              if (emit_now_s) state_q <= ST_EMIT;
            end else begin
              deb_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= ST_SCAN;
            end
          end
        end
        ST_EMIT: begin
          deb_q   <= '0;
          state_q <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // Any row activity restarts the release count, so bounce never re-fires.
          if (sample_s) begin
            if (row_s == 4'b1111) begin
              if ((deb_q + DW'(1)) == DEB_MAX) begin
                deb_q   <= '0;
                busy_q  <= 1'b0;
                col_n_q <= {col_n_q[2:0], col_n_q[3]};
                state_q <= ST_SCAN;
              end else begin
                deb_q <= deb_q + DW'(1);
              end
            end else begin
              deb_q <= '0;
            end
          end
        end
        default: begin
          deb_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_SCAN;
        end
      endcase
    end
  end

  assign col_n  = col_n_q;
  assign digit  = digit_q;
  assign equals = equals_q;
  assign clear  = clear_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a switch-matrix keypad model
// (SCAN_DIV=4, DEBOUNCE=3).
module tb_keypad_scanner;

  logic        clk;
  logic        reset;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  digit;
  logic        equals;
  logic        clear;
  logic        busy;
  logic [15:0] pressed;

  int checks;
  int fails;
  int eq_cnt;
  int clr_cnt;
  int both_cnt;
  int dig_q[$];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .row_n  (row_n),
    .col_n  (col_n),
    .digit  (digit),
    .equals (equals),
    .clear  (clear),
    .busy   (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Closed switch connects its row to its column; rows are pulled up.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row_n[r] = ~|(pressed[r*4 +: 4] & ~col_n);
    end
  end

  always @(negedge clk) begin
    if (equals) begin
      eq_cnt++;
      dig_q.push_back(int'(digit));
    end
    if (clear) clr_cnt++;
    if (equals && clear) both_cnt++;
  end

  task automatic press_key(input int r, input int c, input int hold, input int rel);
    pressed[r*4 + c] = 1'b1;
    repeat (hold) @(negedge clk);
    pressed = 16'h0000;
    repeat (rel) @(negedge clk);
  endtask

  task automatic test_reset;
    int n;
    reset   = 1'b1;
    pressed = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (col_n !== 4'b1110 || digit !== 4'd0 || equals !== 1'b0 || clear !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: col_n=%b digit=%0d eq=%b clr=%b busy=%b, want 1110 0 0 0 0",
               col_n, digit, equals, clear, busy);
    end
    reset = 1'b0;
    n = 0;
    while (col_n === 4'b1110 && n < 12) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (col_n !== 4'b1101) begin
      fails++;
      $display("FAIL idle_rotate1: col_n=%b, want 1101", col_n);
    end
    n = 0;
    while (col_n === 4'b1101 && n < 12) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 4 || col_n !== 4'b1011) begin
      fails++;
      $display("FAIL idle_period: period=%0d col_n=%b, want 4 1011", n, col_n);
    end
  endtask

  task automatic test_hold_key;
    int  base;
    bit  seen;
    base = eq_cnt;
    seen = 1'b0;
    pressed[0*4 + 2] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (equals) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || digit !== 4'd3) begin
      fails++;
      $display("FAIL hold_3_equals: seen=%0d digit=%0d, want 1 3", seen, digit);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (col_n !== 4'b1011 || busy !== 1'b1) begin
      fails++;
      $display("FAIL hold_3_col: col_n=%b busy=%b, want 1011 1", col_n, busy);
    end
    pressed = 16'h0000;
    repeat (40) @(negedge clk);
    checks++;
    if (eq_cnt - base !== 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL hold_3_count: pulses=%0d busy=%b, want 1 0", eq_cnt - base, busy);
    end
  endtask

  task automatic test_sequence;
    int rows[8] = '{0, 2, 3, 3, 2, 0, 0, 0};
    int cols[8] = '{2, 2, 1, 1, 1, 0, 1, 0};
    int exp_d[8] = '{3, 9, 0, 0, 8, 1, 2, 1};
    int base_e;
    int base_c;
    base_e = eq_cnt;
    base_c = clr_cnt;
    for (int k = 0; k < 8; k++) press_key(rows[k], cols[k], 60, 40);
    checks++;
    if (eq_cnt - base_e !== 8 || clr_cnt - base_c !== 0) begin
      fails++;
      $display("FAIL seq_count: equals=%0d clears=%0d, want 8 0", eq_cnt - base_e, clr_cnt - base_c);
    end
    for (int k = 0; k < 8; k++) begin
      if (base_e + k < dig_q.size()) begin
        checks++;
        if (dig_q[base_e + k] !== exp_d[k]) begin
          fails++;
          $display("FAIL seq_digit%0d: got %0d, want %0d", k, dig_q[base_e + k], exp_d[k]);
        end
      end
    end
  endtask

  task automatic test_bounce;
    int base;
    int n;
    base = eq_cnt;
    n = 0;
    while (col_n !== 4'b1101 && n < 40) begin
      @(negedge clk);
      n++;
    end
    pressed[1*4 + 1] = 1'b1;
    repeat (4) @(negedge clk);
    pressed = 16'h0000;
    repeat (4) @(negedge clk);
    pressed[1*4 + 1] = 1'b1;
    repeat (60) @(negedge clk);
    pressed = 16'h0000;
    repeat (4) @(negedge clk);
    pressed[1*4 + 1] = 1'b1;
    repeat (4) @(negedge clk);
    pressed = 16'h0000;
    repeat (50) @(negedge clk);
    checks++;
    if (eq_cnt - base !== 1 || digit !== 4'd5) begin
      fails++;
      $display("FAIL bounce_5: pulses=%0d digit=%0d, want 1 5", eq_cnt - base, digit);
    end
  endtask

  task automatic test_special_keys;
    int base_e;
    int base_c;
    base_e = eq_cnt;
    base_c = clr_cnt;
    press_key(3, 0, 60, 40);
    checks++;
    if (clr_cnt - base_c !== 1 || eq_cnt - base_e !== 0 || digit !== 4'd5) begin
      fails++;
      $display("FAIL star_clear: clears=%0d equals=%0d digit=%0d, want 1 0 5",
               clr_cnt - base_c, eq_cnt - base_e, digit);
    end
    press_key(3, 2, 60, 40);
    press_key(0, 3, 60, 40);
    checks++;
    if (clr_cnt - base_c !== 1 || eq_cnt - base_e !== 0) begin
      fails++;
      $display("FAIL hash_a_silent: clears=%0d equals=%0d, want 1 0", clr_cnt - base_c, eq_cnt - base_e);
    end
  endtask

  task automatic test_multi_and_reset;
    int base_e;
    int base_c;
    int n;
    base_e = eq_cnt;
    base_c = clr_cnt;
    pressed[0*4 + 0] = 1'b1;
    pressed[1*4 + 0] = 1'b1;
    repeat (60) @(negedge clk);
    pressed = 16'h0000;
    repeat (20) @(negedge clk);
    checks++;
    if (eq_cnt - base_e !== 0 || clr_cnt - base_c !== 0) begin
      fails++;
      $display("FAIL two_rows: equals=%0d clears=%0d, want 0 0", eq_cnt - base_e, clr_cnt - base_c);
    end
    pressed[2*4 + 0] = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL seven_busy: busy=%b, want 1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    pressed = 16'h0000;
    checks++;
    if (col_n !== 4'b1110 || busy !== 1'b0 || equals !== 1'b0 || digit !== 4'd0) begin
      fails++;
      $display("FAIL reset_debounce: col_n=%b busy=%b eq=%b digit=%0d, want 1110 0 0 0",
               col_n, busy, equals, digit);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (eq_cnt - base_e !== 0) begin
      fails++;
      $display("FAIL reset_no_strobe: equals=%0d, want 0", eq_cnt - base_e);
    end
    checks++;
    if (both_cnt !== 0) begin
      fails++;
      $display("FAIL eq_clr_overlap: cycles=%0d, want 0", both_cnt);
    end
  endtask

  initial begin
    checks   = 0;
    fails    = 0;
    eq_cnt   = 0;
    clr_cnt  = 0;
    both_cnt = 0;
    pressed  = 16'h0000;
    reset    = 1'b1;
    test_reset();
    test_hold_key();
    test_sequence();
    test_bounce();
    test_special_keys();
    test_multi_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
